// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller with fixed access latency, byte strobes and tohost finish
//
// Purpose:
//   Single-outstanding load/store port in front of a DEPTH_WORDS x 32 array.
//   A request is accepted in IDLE. Its response appears as a one-cycle ready
//   pulse LATENCY cycles after the accepting edge. Array side effects
//   (write commit, r_data capture) happen only on the edge that enters RESP.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   addr      in   byte address of the request
//   r_enable  in   read request
//   w_enable  in   write request
//   w_size    in   0=byte, 1=half, 2/3=word
//   w_data    in   right-aligned write data
//   r_data    out  full aligned word, meaningful while ready=1
//   ready     out  one-cycle response strobe
//   err       out  error qualifier, meaningful while ready=1
//   finish    out  sticky flag, set by a write to TOHOST_ADDR

module dmem_ctrl #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 DEPTH_WORDS = 1024,
  parameter int                 LATENCY     = 2,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              r_enable,
  input  logic              w_enable,
  input  logic [1:0]        w_size,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              ready,
  output logic              err,
  output logic              finish
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]        LAT_M1    = 4'(LATENCY - 1);
  localparam bit                LAT_ONE   = (LATENCY == 1);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        wsize_q;
  logic              rd_q;
  logic              wr_q;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              finish_q;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Request fields seen by the response logic. With LATENCY=1 the response
  // edge is the accepting edge, so the live inputs are used instead of the
  // captured copies.
  logic              req_d;
  logic              in_idle_d;
  logic [ADDR_W-1:0] cur_addr_d;
  logic [DATA_W-1:0] cur_data_d;
  logic [1:0]        cur_size_d;
  logic              cur_rd_d;
  logic              cur_wr_d;
  logic              enter_resp_d;
  logic [IDX_W-1:0]  idx_d;
  logic              tohost_d;
  logic              misalign_d;
  logic              oor_d;
  logic              err_d;
  logic              mem_we_d;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wword_d;
  logic [DATA_W-1:0] rd_word_d;

  always_comb begin
    req_d      = r_enable | w_enable;
    in_idle_d  = (state_q == S_IDLE);
    cur_addr_d = in_idle_d ? addr     : addr_q;
    cur_data_d = in_idle_d ? w_data   : wdata_q;
    cur_size_d = in_idle_d ? w_size   : wsize_q;
    cur_rd_d   = in_idle_d ? r_enable : rd_q;
    cur_wr_d   = in_idle_d ? w_enable : wr_q;

    enter_resp_d = (LAT_ONE && in_idle_d && req_d) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd1));

    idx_d      = cur_addr_d[IDX_W+1:2];
    tohost_d   = cur_wr_d & ~cur_rd_d & (cur_addr_d == TOHOST_ADDR);
    misalign_d = cur_wr_d & ~cur_rd_d &
                 (((cur_size_d == 2'd1) & cur_addr_d[0]) |
                  (cur_size_d[1] & (cur_addr_d[1:0] != 2'b00)));
    oor_d      = (cur_addr_d >= MEM_BYTES);
    // tohost overrides the range check; a combined read+write is always an error
    err_d      = (cur_rd_d & cur_wr_d) | (~tohost_d & (oor_d | misalign_d));
    mem_we_d   = enter_resp_d & cur_wr_d & ~err_d & ~tohost_d;

    be_d    = 4'hF;
    wword_d = cur_data_d;
    case (cur_size_d)
      2'd0: begin
        be_d    = 4'b0001 << cur_addr_d[1:0];
        wword_d = {4{cur_data_d[7:0]}};
      end
      2'd1: begin
        be_d    = cur_addr_d[1] ? 4'b1100 : 4'b0011;
        wword_d = {2{cur_data_d[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wword_d = cur_data_d;
      end
    endcase

    rd_word_d = mem_q[idx_d];
  end

  // Backing array: never reset, written only on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx_d][8*b +: 8] <= wword_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wsize_q  <= 2'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_d) begin
            addr_q  <= addr;
            wdata_q <= w_data;
            wsize_q <= w_size;
            rd_q    <= r_enable;
            wr_q    <= w_enable;
            if (LAT_ONE) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd1) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (enter_resp_d) begin
        ready_q  <= 1'b1;
        err_q    <= err_d;
        rdata_q  <= err_d ? '0 : rd_word_d;
        finish_q <= finish_q | tohost_d;
      end
    end
  end

  assign r_data = rdata_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - table-driven bench for dmem_ctrl with latency sweep instances
//
// Purpose:
//   Drives a LATENCY=2 instance through a table of requests with
//   hand-computed responses, then checks reset drop and sticky finish, then
//   compares ready patterns of LATENCY=1/2/5 instances under continuous reads.
//
// Ports: none (top-level bench).

module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        r_enable;
  logic        w_enable;
  logic [1:0]  w_size;
  logic [31:0] w_data;

  logic [31:0] r_data, r_data_l1, r_data_l5;
  logic        ready,  ready_l1,  ready_l5;
  logic        err,    err_l1,    err_l5;
  logic        finish, finish_l1, finish_l5;

  int n_vec;
  int n_miss;

  dmem_ctrl #(.LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .r_enable(r_enable),
    .w_enable(w_enable), .w_size(w_size), .w_data(w_data),
    .r_data(r_data), .ready(ready), .err(err), .finish(finish)
  );

  dmem_ctrl #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .addr(addr), .r_enable(r_enable),
    .w_enable(w_enable), .w_size(w_size), .w_data(w_data),
    .r_data(r_data_l1), .ready(ready_l1), .err(err_l1), .finish(finish_l1)
  );

  dmem_ctrl #(.LATENCY(5)) u_l5 (
    .clk(clk), .reset(reset), .addr(addr), .r_enable(r_enable),
    .w_enable(w_enable), .w_size(w_size), .w_data(w_data),
    .r_data(r_data_l5), .ready(ready_l5), .err(err_l5), .finish(finish_l5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_fin;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic e, input logic c, input logic [31:0] rdv,
                              input logic f);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.addr = a; v.wdata = wd;
    v.exp_err = e; v.chk_rd = c; v.exp_rdata = rdv; v.exp_fin = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h want %h", name, act, exp);
      n_miss++;
    end
  endtask

  // One request on the LATENCY=2 instance; enables are held for exactly one edge.
  task automatic do_req(input vec_t v, input string tag);
    int  k;
    logic seen;
    @(negedge clk);
    r_enable = v.rd; w_enable = v.wr; w_size = v.size; addr = v.addr; w_data = v.wdata;
    @(posedge clk);
    seen = 1'b0;
    k    = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        r_enable = 1'b0;
        w_enable = 1'b0;
      end
      if (ready) begin
        seen = 1'b1;
        k    = i;
      end
    end
    n_vec++;
    chk({tag, " latency"}, k, 32'd2);
    if (seen) begin
      chk({tag, " err"}, {31'd0, err}, {31'd0, v.exp_err});
      if (v.chk_rd) chk({tag, " r_data"}, r_data, v.exp_rdata);
      chk({tag, " finish"}, {31'd0, finish}, {31'd0, v.exp_fin});
      @(negedge clk);
      chk({tag, " pulse width"}, {31'd0, ready}, 32'd0);
      if (v.chk_rd) chk({tag, " r_data hold"}, r_data, v.exp_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic any_ready;
    logic exp1, exp2, exp5;
    n_vec  = 0;
    n_miss = 0;

    //          rd wr sz  addr          wdata         err chk  rdata         fin
    vecs[0]  = mk(0, 1, 2, 32'h0000_0010, 32'hDEADBEEF, 0, 0, 32'h0,        0);
    vecs[1]  = mk(1, 0, 0, 32'h0000_0010, 32'h0,        0, 1, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 1, 2, 32'h0000_0020, 32'h11223344, 0, 0, 32'h0,        0);
    vecs[3]  = mk(0, 1, 0, 32'h0000_0023, 32'h0000_00AA, 0, 0, 32'h0,       0);
    vecs[4]  = mk(0, 1, 1, 32'h0000_0020, 32'h0000_BBCC, 0, 0, 32'h0,       0);
    vecs[5]  = mk(1, 0, 0, 32'h0000_0020, 32'h0,        0, 1, 32'hAA22BBCC, 0);
    vecs[6]  = mk(0, 1, 1, 32'h0000_0021, 32'h0000_1234, 1, 1, 32'h0,       0);
    vecs[7]  = mk(1, 0, 0, 32'h0000_0020, 32'h0,        0, 1, 32'hAA22BBCC, 0);
    vecs[8]  = mk(1, 0, 0, 32'h1000_0000, 32'h0,        1, 1, 32'h0,        0);
    vecs[9]  = mk(1, 1, 2, 32'h0000_0020, 32'h0,        1, 1, 32'h0,        0);
    vecs[10] = mk(1, 0, 0, 32'h0000_0020, 32'h0,        0, 1, 32'hAA22BBCC, 0);
    vecs[11] = mk(0, 1, 2, 32'h0000_0022, 32'h5555_5555, 1, 1, 32'h0,       0);
    vecs[12] = mk(0, 1, 2, 32'h0000_0FFC, 32'h0BAD_F00D, 0, 0, 32'h0,       0);
    vecs[13] = mk(1, 0, 0, 32'h0000_0FFC, 32'h0,        0, 1, 32'h0BADF00D, 0);
    vecs[14] = mk(0, 1, 2, 32'h0000_1000, 32'h0000_0001, 0, 0, 32'h0,       1);
    vecs[15] = mk(1, 0, 0, 32'h0000_0010, 32'h0,        0, 1, 32'hDEADBEEF, 1);

    reset = 1'b1; r_enable = 1'b0; w_enable = 1'b0; w_size = 2'd0; addr = '0; w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    chk("reset ready",  {31'd0, ready},  32'd0);
    chk("reset err",    {31'd0, err},    32'd0);
    chk("reset finish", {31'd0, finish}, 32'd0);
    chk("reset r_data", r_data,          32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-WAIT drops a word write of 0 to 0x10 and clears finish.
    @(negedge clk);
    w_enable = 1'b1; w_size = 2'd2; addr = 32'h10; w_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    w_enable = 1'b0;
    reset    = 1'b1;
    #1;
    n_vec++;
    chk("midwait reset ready",  {31'd0, ready},  32'd0);
    chk("midwait reset err",    {31'd0, err},    32'd0);
    chk("midwait reset finish", {31'd0, finish}, 32'd0);
    chk("midwait reset r_data", r_data,          32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    any_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_ready = any_ready | ready;
    end
    n_vec++;
    chk("dropped request ready", {31'd0, any_ready}, 32'd0);
    chk("finish after reset",    {31'd0, finish},    32'd0);
    do_req(mk(1, 0, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0), "no write after drop");

    // Latency sweep: continuous reads into freshly reset instances.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    r_enable = 1'b1; w_enable = 1'b0; addr = 32'h10;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp1 = ((k % 2) == 1);
      exp2 = ((k % 3) == 2);
      exp5 = ((k % 6) == 5);
      n_vec++;
      chk($sformatf("sweep L1 k=%0d ready", k), {31'd0, ready_l1}, {31'd0, exp1});
      chk($sformatf("sweep L2 k=%0d ready", k), {31'd0, ready},    {31'd0, exp2});
      chk($sformatf("sweep L5 k=%0d ready", k), {31'd0, ready_l5}, {31'd0, exp5});
      if (exp1) chk($sformatf("sweep L1 k=%0d err", k), {31'd0, err_l1}, 32'd0);
      if (exp5) chk($sformatf("sweep L5 k=%0d err", k), {31'd0, err_l5}, 32'd0);
    end
    r_enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the minuteCore load/store port.
- Accepts one read or write request at a time and applies byte/half/word write strobes.
- Models a fixed multi-cycle access latency with a one-cycle ready pulse.
- Flags error responses and raises a sticky finish when the program writes the tohost word.

Parameters:
- ADDR_W, 32, request address width in bits.
- DATA_W, 32, data width in bits; fixed at 32 for this block.
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array; power of two.
- LATENCY, 2, cycles from the accepting clock edge to the ready pulse; legal range 1..15.
- TOHOST_ADDR, 32'h0000_1000, byte address whose write signals program completion.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_W  byte address of the request.
- r_enable  input  1  read request.
- w_enable  input  1  write request.
- w_size  input  2  write size: 0=byte, 1=half, 2=word, 3=word.
- w_data  input  DATA_W  write data, right-aligned (byte in [7:0], half in [15:0]).
- r_data  output  DATA_W  full aligned word read; valid only while ready=1.
- ready  output  1  one-cycle response strobe.
- err  output  1  error qualifier; valid only while ready=1.
- finish  output  1  sticky completion flag.

Behaviour:
- Reset (async, any state): FSM to IDLE; latency counter to 0; ready=0, err=0, r_data=0, finish=0. Memory array is not cleared. A reset during WAIT or RESP drops the in-flight request: it produces no ready pulse and no write.
- FSM states IDLE, WAIT, RESP.
- IDLE: at a rising edge with r_enable|w_enable=1, capture addr, w_data, w_size and the request type, then go to WAIT. If LATENCY=1, go directly to RESP.
- WAIT: the counter is loaded with LATENCY-1 on acceptance and decrements once per cycle. Go to RESP when it reaches 1. Enables are ignored in WAIT.
- RESP: ready=1 for exactly one cycle, then return to IDLE. ready rises exactly LATENCY cycles after the accepting edge.
- Back-to-back: if an enable is high in the cycle after RESP, a new request is accepted at that IDLE edge. Minimum request spacing is LATENCY+1 cycles.
- Side effects occur on the edge entering RESP: the write is committed and r_data is registered.
- Word index: addr[log2(DEPTH_WORDS)+1:2].
- Writes:
  - Byte: lane addr[1:0] receives w_data[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} receive w_data[15:0].
  - Word: all four lanes receive w_data.
  - Lanes not written keep their value. Little-endian.
- Reads: r_data = the whole word at the index, with no sub-word extraction. r_data holds its last value outside RESP.
- Error conditions:
  - Out-of-range address, i.e. addr >= 4*DEPTH_WORDS.
  - Misaligned half (addr[0]=1).
  - Misaligned word (addr[1:0]!=0).
  - r_enable and w_enable both high at acceptance.
- Error response: no array write; r_data=0; err=1 during the RESP cycle.
- tohost: a write with addr == TOHOST_ADDR sets finish=1 on the RESP edge, takes priority over the out-of-range check, and does not modify the array. finish stays high until reset.
- No reads or writes to the array occur except on the RESP edge.

Test Plan:
- Reset check: hold reset high for 2 cycles mid-WAIT, then release. Required: ready=err=finish=0 and r_data=0, with no ready pulse for the dropped request.
- Word round trip: write 0xDEADBEEF to 0x10 (size 2), then read 0x10. Required: ready rises 2 cycles after each accept, err=0, r_data=0xDEADBEEF.
- Byte/half merge:
  - Starting from word 0x11223344 at 0x20, write byte 0xAA to 0x23 and half 0xBBCC to 0x20.
  - Required: a read of 0x20 returns 0xAA22BBCC.
- Errors:
  - Half write to 0x21: err=1 and word unchanged.
  - Read of 0x1000_0000: err=1, r_data=0.
  - r_enable and w_enable together: err=1, no write.
- Finish: word write 0x1 to 0x1000. Required: finish=1 on the RESP edge and stays 1 through later requests until reset.
- Latency sweep: set LATENCY=1 and LATENCY=5, then issue back-to-back reads. Required: ready is exactly LATENCY cycles after accept, accepts are spaced LATENCY+1 cycles apart, and every pulse is exactly one cycle wide.
